// File: rtl/eth_tx_arbiter.sv
// Packet-granular two-port AXI-Stream arbiter feeding the 10G MAC transmit path.
// Define ETH_TX_ARB_STRICT_PRIO_EN to make port 0 always win the IDLE tie-break.
module eth_tx_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = 8,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk156,
   input  logic                  sys_rst_n,

   input  logic                  s0_axis_tx_tvalid,
   output logic                  s0_axis_tx_tready,
   input  logic [DATA_WIDTH-1:0] s0_axis_tx_tdata,
   input  logic [KEEP_WIDTH-1:0] s0_axis_tx_tkeep,
   input  logic                  s0_axis_tx_tlast,
   input  logic                  s0_axis_tx_tuser,

   input  logic                  s1_axis_tx_tvalid,
   output logic                  s1_axis_tx_tready,
   input  logic [DATA_WIDTH-1:0] s1_axis_tx_tdata,
   input  logic [KEEP_WIDTH-1:0] s1_axis_tx_tkeep,
   input  logic                  s1_axis_tx_tlast,
   input  logic                  s1_axis_tx_tuser,

   output logic                  m_axis_tx_tvalid,
   input  logic                  m_axis_tx_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tx_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tx_tkeep,
   output logic                  m_axis_tx_tlast,
   output logic                  m_axis_tx_tuser,

   output logic [1:0]            grant,
   output logic [CNT_WIDTH-1:0]  frame_cnt0,
   output logic [CNT_WIDTH-1:0]  frame_cnt1
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t state;
   logic   out_free;
   logic   acc0, acc1;
   logic   last0, last1;
   logic   tie_pick1;

   always_comb begin
      out_free          = !m_axis_tx_tvalid || m_axis_tx_tready;
      s0_axis_tx_tready = (state == OWN0) && out_free;
      s1_axis_tx_tready = (state == OWN1) && out_free;
      acc0              = s0_axis_tx_tvalid && s0_axis_tx_tready;
      acc1              = s1_axis_tx_tvalid && s1_axis_tx_tready;
      last0             = acc0 && s0_axis_tx_tlast;
      last1             = acc1 && s1_axis_tx_tlast;
   end

`ifdef ETH_TX_ARB_STRICT_PRIO_EN
   always_comb tie_pick1 = 1'b0;
`else
   logic last_srv;

   // Reset to 1 so port 0 wins the first tie.
   always_ff @(posedge clk156) begin
      if (!sys_rst_n)
         last_srv <= 1'b1;
      else if (last0)
         last_srv <= 1'b0;
      else if (last1)
         last_srv <= 1'b1;
   end

   always_comb tie_pick1 = !last_srv;
`endif

   always_ff @(posedge clk156) begin
      if (!sys_rst_n) begin
         state            <= IDLE;
         grant            <= 2'b00;
         m_axis_tx_tvalid <= 1'b0;
         m_axis_tx_tdata  <= '0;
         m_axis_tx_tkeep  <= '0;
         m_axis_tx_tlast  <= 1'b0;
         m_axis_tx_tuser  <= 1'b0;
         frame_cnt0       <= '0;
         frame_cnt1       <= '0;
      end else begin
         if (acc0) begin
            m_axis_tx_tvalid <= 1'b1;
            m_axis_tx_tdata  <= s0_axis_tx_tdata;
            m_axis_tx_tkeep  <= s0_axis_tx_tkeep;
            m_axis_tx_tlast  <= s0_axis_tx_tlast;
            m_axis_tx_tuser  <= s0_axis_tx_tuser;
         end else if (acc1) begin
            m_axis_tx_tvalid <= 1'b1;
            m_axis_tx_tdata  <= s1_axis_tx_tdata;
            m_axis_tx_tkeep  <= s1_axis_tx_tkeep;
            m_axis_tx_tlast  <= s1_axis_tx_tlast;
            m_axis_tx_tuser  <= s1_axis_tx_tuser;
         end else if (m_axis_tx_tready) begin
            m_axis_tx_tvalid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (s0_axis_tx_tvalid && (!s1_axis_tx_tvalid || !tie_pick1)) begin
                  state <= OWN0;
                  grant <= 2'b01;
               end else if (s1_axis_tx_tvalid) begin
                  state <= OWN1;
                  grant <= 2'b10;
               end
            end
            OWN0: begin
               if (last0) begin
                  state      <= IDLE;
                  grant      <= 2'b00;
                  frame_cnt0 <= frame_cnt0 + CNT_WIDTH'(1);
               end
            end
            OWN1: begin
               if (last1) begin
                  state      <= IDLE;
                  grant      <= 2'b00;
                  frame_cnt1 <= frame_cnt1 + CNT_WIDTH'(1);
               end
            end
            default: begin
               state <= IDLE;
               grant <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: single frame, tie-break, backpressure, valid gap, wrap and reset.
module tb_eth_tx_arbiter;

   logic        clk156 = 1'b0;
   logic        sys_rst_n;
   logic        s0_tvalid, s0_tready, s0_tlast, s0_tuser;
   logic [63:0] s0_tdata;
   logic [7:0]  s0_tkeep;
   logic        s1_tvalid, s1_tready, s1_tlast, s1_tuser;
   logic [63:0] s1_tdata;
   logic [7:0]  s1_tkeep;
   logic        m_tvalid, m_tready, m_tlast, m_tuser;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic [1:0]  grant;
   logic [3:0]  cnt0, cnt1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk156 = ~clk156;

   eth_tx_arbiter #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .CNT_WIDTH(4)) dut (
      .clk156           (clk156),
      .sys_rst_n        (sys_rst_n),
      .s0_axis_tx_tvalid(s0_tvalid),
      .s0_axis_tx_tready(s0_tready),
      .s0_axis_tx_tdata (s0_tdata),
      .s0_axis_tx_tkeep (s0_tkeep),
      .s0_axis_tx_tlast (s0_tlast),
      .s0_axis_tx_tuser (s0_tuser),
      .s1_axis_tx_tvalid(s1_tvalid),
      .s1_axis_tx_tready(s1_tready),
      .s1_axis_tx_tdata (s1_tdata),
      .s1_axis_tx_tkeep (s1_tkeep),
      .s1_axis_tx_tlast (s1_tlast),
      .s1_axis_tx_tuser (s1_tuser),
      .m_axis_tx_tvalid (m_tvalid),
      .m_axis_tx_tready (m_tready),
      .m_axis_tx_tdata  (m_tdata),
      .m_axis_tx_tkeep  (m_tkeep),
      .m_axis_tx_tlast  (m_tlast),
      .m_axis_tx_tuser  (m_tuser),
      .grant            (grant),
      .frame_cnt0       (cnt0),
      .frame_cnt1       (cnt1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk156);
         #1;
      end
   endtask

   task automatic drv0(input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic u);
      s0_tvalid = v; s0_tdata = d; s0_tkeep = k; s0_tlast = l; s0_tuser = u;
   endtask

   task automatic drv1(input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic u);
      s1_tvalid = v; s1_tdata = d; s1_tkeep = k; s1_tlast = l; s1_tuser = u;
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      drv0(0, '0, '0, 0, 0);
      drv1(0, '0, '0, 0, 0);
      m_tready = 1'b1;
      step(2);
      sys_rst_n = 1'b1;
   endtask

   initial begin
      // ---- reset state ----
      do_reset();
      #1;
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_grant", grant, 0);
      check("rst_cnt0", cnt0, 0);
      check("rst_cnt1", cnt1, 0);
      check("rst_rdy0", s0_tready, 0);
      check("rst_rdy1", s1_tready, 0);

      // ---- single port, 3-beat frame, continuous ready ----
      drv0(1, 64'hA0, 8'hFF, 0, 0);
      step(1);
      check("t1_grant", grant, 2'b01);
      check("t1_nvalid", m_tvalid, 0);
      step(1);
      check("t1_b0_v", m_tvalid, 1);
      check("t1_b0_d", m_tdata, 64'hA0);
      check("t1_b0_k", m_tkeep, 8'hFF);
      drv0(1, 64'hA1, 8'hFF, 0, 1);
      step(1);
      check("t1_b1_d", m_tdata, 64'hA1);
      check("t1_b1_u", m_tuser, 1);
      check("t1_b1_l", m_tlast, 0);
      drv0(1, 64'hA2, 8'h0F, 1, 0);
      step(1);
      check("t1_b2_d", m_tdata, 64'hA2);
      check("t1_b2_k", m_tkeep, 8'h0F);
      check("t1_b2_l", m_tlast, 1);
      check("t1_cnt0", cnt0, 1);
      check("t1_grant_idle", grant, 0);
      drv0(0, '0, '0, 0, 0);
      step(1);
      check("t1_drain", m_tvalid, 0);

      // ---- tie-break from reset ----
      do_reset();
      drv0(1, 64'h100, 8'hFF, 0, 0);
      drv1(1, 64'h200, 8'hFF, 0, 0);
      step(1);
      check("t2_g1", grant, 2'b01);
      step(1);
      check("t2_p0a", m_tdata, 64'h100);
      drv0(1, 64'h101, 8'hFF, 1, 0);
      step(1);
      check("t2_p0b", m_tdata, 64'h101);
      check("t2_g2", grant, 2'b00);
      drv0(1, 64'h110, 8'hFF, 0, 0);
      step(1);
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
      check("t2_g3", grant, 2'b01);
      step(1);
      check("t2_p0c", m_tdata, 64'h110);
      drv0(1, 64'h111, 8'hFF, 1, 0);
      step(1);
      check("t2_p0d", m_tdata, 64'h111);
      check("t2_g4", grant, 2'b00);
      drv0(1, 64'h120, 8'hFF, 0, 0);
      step(1);
      check("t2_g5", grant, 2'b01);
      check("t2_cnt1", cnt1, 0);
`else
      check("t2_g3", grant, 2'b10);
      check("t2_gap", m_tvalid, 0);
      step(1);
      check("t2_p1a", m_tdata, 64'h200);
      drv1(1, 64'h201, 8'hFF, 1, 0);
      step(1);
      check("t2_p1b", m_tdata, 64'h201);
      check("t2_g4", grant, 2'b00);
      drv1(1, 64'h210, 8'hFF, 0, 0);
      step(1);
      check("t2_g5", grant, 2'b01);
      step(1);
      check("t2_p0c", m_tdata, 64'h110);
`endif

      // ---- backpressure mid-frame ----
      do_reset();
      drv0(1, 64'h300, 8'hFF, 0, 0);
      step(2);
      check("t3_b0", m_tdata, 64'h300);
      drv0(1, 64'h301, 8'hFF, 0, 0);
      m_tready = 1'b0;
      #1;
      check("t3_rdy_low", s0_tready, 0);
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("t3_hold_d", m_tdata, 64'h300);
         check("t3_hold_v", m_tvalid, 1);
      end
      m_tready = 1'b1;
      #1;
      check("t3_rdy_high", s0_tready, 1);
      step(1);
      check("t3_b1", m_tdata, 64'h301);
      drv0(1, 64'h302, 8'hFF, 1, 0);
      step(1);
      check("t3_b2", m_tdata, 64'h302);
      check("t3_cnt0", cnt0, 1);
      drv0(0, '0, '0, 0, 0);
      step(1);
      check("t3_drain", m_tvalid, 0);

      // ---- tvalid gap mid-frame with port 1 waiting ----
      do_reset();
      drv0(1, 64'h400, 8'hFF, 0, 0);
      drv1(1, 64'h500, 8'hFF, 1, 0);
      step(2);
      check("t4_b0", m_tdata, 64'h400);
      drv0(0, 64'h401, 8'hFF, 1, 0);
      step(1);
      check("t4_gap1_g", grant, 2'b01);
      check("t4_bubble", m_tvalid, 0);
      step(1);
      check("t4_gap2_g", grant, 2'b01);
      #1;
      check("t4_rdy1", s1_tready, 0);
      drv0(1, 64'h401, 8'hFF, 1, 0);
      step(1);
      check("t4_b1", m_tdata, 64'h401);
      check("t4_idle", grant, 2'b00);
      drv0(0, '0, '0, 0, 0);
      step(1);
      check("t4_g1", grant, 2'b10);
      step(1);
      check("t4_p1", m_tdata, 64'h500);

      // ---- counter wrap on port 1, then reset mid-frame ----
      do_reset();
      drv1(1, 64'h600, 8'h01, 1, 0);
      step(2);
      check("t5_cnt1_1", cnt1, 1);
      step(28);
      check("t5_cnt1_15", cnt1, 15);
      check("t5_idle", grant, 2'b00);
      step(1);
      check("t5_own1", grant, 2'b10);
      step(1);
      check("t5_wrap", cnt1, 0);
      drv1(1, 64'h700, 8'hFF, 0, 0);
      step(2);
      check("t5_mid_v", m_tvalid, 1);
      check("t5_mid_g", grant, 2'b10);
      sys_rst_n = 1'b0;
      step(1);
      check("t5_rst_v", m_tvalid, 0);
      check("t5_rst_g", grant, 2'b00);
      check("t5_rst_rdy1", s1_tready, 0);
      sys_rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
